// File: rtl/lsu_dmem.sv
// Load/store unit front-end for a byte-addressed data memory with combinational reads.
// Sub-word stores are done as read-modify-write; out-of-range or illegal-size requests are rejected.
module lsu_dmem #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwr
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        wr_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic        err_r;

    logic        accept_s;
    logic [32:0] nbytes_s;
    logic [32:0] end_addr_s;
    logic        err_s;
    logic [31:0] load_data_s;
    logic [31:0] merged_s;

    assign accept_s = req_valid && (state_r == IDLE);

    // Range/size check of the incoming request; 33-bit sum so the address cannot wrap.
    always_comb begin
        nbytes_s = 33'd4;
        case (req_size)
            2'b00:   nbytes_s = 33'd1;
            2'b01:   nbytes_s = 33'd2;
            2'b10:   nbytes_s = 33'd4;
            default: nbytes_s = 33'd4;
        endcase
        end_addr_s = {1'b0, req_addr} + nbytes_s;
        if (req_size == 2'b11) begin
            err_s = 1'b1;
        end else if (end_addr_s > 33'(MEM_BYTES)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Load extension and sub-word store merge from the memory read word.
    always_comb begin
        load_data_s = mem_rdata;
        merged_s    = data_r;
        case (size_r)
            2'b00: begin
                load_data_s = {{24{signed_r & mem_rdata[7]}}, mem_rdata[7:0]};
                merged_s    = {mem_rdata[31:8], data_r[7:0]};
            end
            2'b01: begin
                load_data_s = {{16{signed_r & mem_rdata[15]}}, mem_rdata[15:0]};
                merged_s    = {mem_rdata[31:16], data_r[15:0]};
            end
            2'b10: begin
                load_data_s = mem_rdata;
                merged_s    = data_r;
            end
            default: begin
                load_data_s = 32'd0;
                merged_s    = data_r;
            end
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_next_s = IDLE;
                end else if (err_s) begin
                    state_next_s = RESP;
                end else if (!req_wr) begin
                    state_next_s = READ;
                end else if (req_size == 2'b10) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = READ;
                end
            end
            READ: begin
                if (wr_r) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = RESP;
                end
            end
            WRITE:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request fields; data_r carries store data, then the merged word or the load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r     <= 1'b0;
            size_r   <= 2'b00;
            signed_r <= 1'b0;
            addr_r   <= 32'd0;
            data_r   <= 32'd0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wr_r     <= req_wr;
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        addr_r   <= req_addr;
                        data_r   <= req_wdata;
                        err_r    <= err_s;
                    end
                end
                READ: begin
                    if (wr_r) begin
                        data_r <= merged_s;
                    end else begin
                        data_r <= load_data_s;
                    end
                end
                WRITE: begin
                    data_r <= data_r;
                end
                RESP: begin
                    err_r <= err_r;
                end
                default: begin
                    err_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == RESP);
    assign resp_err   = (state_r == RESP) && err_r;
    assign resp_rdata = ((state_r == RESP) && !wr_r && !err_r) ? data_r : 32'd0;

    // The write strobe is masked by reset so an interrupted WRITE never reaches memory.
    assign mem_memwr  = (state_r == WRITE) && !rst;
    assign mem_raddr  = addr_r;
    assign mem_waddr  = addr_r;
    assign mem_wdata  = data_r;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a 256-byte little-endian memory model (async read, negedge write).
module tb_lsu_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_memwr;

    logic [7:0]  mem [0:255];
    logic        mem_clr;
    int          n_vec = 0;
    int          n_bad = 0;

    lsu_dmem #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_memwr(mem_memwr)
    );

    always #5 clk = ~clk;

    assign mem_rdata = {mem[8'(mem_raddr[7:0] + 8'd3)], mem[8'(mem_raddr[7:0] + 8'd2)],
                        mem[8'(mem_raddr[7:0] + 8'd1)], mem[mem_raddr[7:0]]};

    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_memwr) begin
            for (int i = 0; i < 4; i++) mem[8'(mem_waddr[7:0] + 8'(i))] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE (#1 after a posedge); return latency and what was observed.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nwr, output logic [31:0] lwaddr, output logic [31:0] lwdata);
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nwr = 0; lwaddr = 32'hDEADBEEF; lwdata = 32'hDEADBEEF;
        while (!resp_valid && lat < 10) begin
            if (mem_memwr) begin
                nwr++; lwaddr = mem_waddr; lwdata = mem_wdata;
            end
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err;
        @(posedge clk); #1;
    endtask

    int          lat, nwr, acc;
    logic [31:0] rd, lwa, lwd;
    logic        er;

    initial begin
        rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mem_clr = 1'b0;
        check_vec("rst_ready",  32'(req_ready),  32'd1);
        check_vec("rst_rvalid", 32'(resp_valid), 32'd0);
        check_vec("rst_err",    32'(resp_err),   32'd0);
        check_vec("rst_rdata",  resp_rdata,      32'd0);
        check_vec("rst_memwr",  32'(mem_memwr),  32'd0);
        check_vec("rst_raddr",  mem_raddr,       32'd0);
        check_vec("rst_waddr",  mem_waddr,       32'd0);
        check_vec("rst_wdata",  mem_wdata,       32'd0);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, lat, rd, er, nwr, lwa, lwd);
        check_vec("sw_lat",   32'(lat), 32'd2);
        check_vec("sw_nwr",   32'(nwr), 32'd1);
        check_vec("sw_waddr", lwa, 32'h10);
        check_vec("sw_wdata", lwd, 32'h8899AABB);
        check_vec("sw_err",   32'(er), 32'd0);
        check_vec("sw_rdata", rd, 32'd0);

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lw_lat",   32'(lat), 32'd2);
        check_vec("lw_rdata", rd, 32'h8899AABB);
        check_vec("lw_nwr",   32'(nwr), 32'd0);
        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lb_s",  rd, 32'hFFFFFF99);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lhu",   rd, 32'h000099AA);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lh_s",  rd, 32'hFFFF8899);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lbu",   rd, 32'h00000088);

        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hFFFFFF55, lat, rd, er, nwr, lwa, lwd);
        check_vec("sb_lat",   32'(lat), 32'd3);
        check_vec("sb_nwr",   32'(nwr), 32'd1);
        check_vec("sb_wdata", lwd, 32'h8899AA55);
        check_vec("sb_mem",   {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h8899AA55);

        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hDEAD1234, lat, rd, er, nwr, lwa, lwd);
        check_vec("sh_lat",   32'(lat), 32'd3);
        check_vec("sh_waddr", lwa, 32'h12);
        check_vec("sh_wdata", lwd, 32'h00001234);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("lw_after_sh", rd, 32'h1234AA55);

        do_req(1'b0, 2'b10, 1'b0, 32'd253, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("e253_lat", 32'(lat), 32'd1);
        check_vec("e253_err", 32'(er), 32'd1);
        check_vec("e253_rd",  rd, 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("esz_err",  32'(er), 32'd1);
        check_vec("esz_lat",  32'(lat), 32'd1);
        do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, lat, rd, er, nwr, lwa, lwd);
        check_vec("ewrap_err", 32'(er), 32'd1);
        check_vec("ewrap_nwr", 32'(nwr), 32'd0);
        check_vec("ewrap_lat", 32'(lat), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'd252, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("b252_err", 32'(er), 32'd0);
        check_vec("b252_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'd255, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("b255_err", 32'(er), 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'd255, 32'h0, lat, rd, er, nwr, lwa, lwd);
        check_vec("h255_err", 32'(er), 32'd1);

        // Reset arriving in the WRITE cycle of a word store.
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_vec("rstw_memwr", 32'(mem_memwr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_vec("rstw_ready",  32'(req_ready), 32'd1);
        check_vec("rstw_rvalid", 32'(resp_valid), 32'd0);
        check_vec("rstw_mem",    {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'd0);
        @(posedge clk); #1;
        check_vec("rstw_rvalid2", 32'(resp_valid), 32'd0);

        // Three word loads with req_valid held high.
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        acc = 0;
        for (int c = 0; c < 9; c++) begin
            check_vec($sformatf("b2b_ready%0d", c), 32'(req_ready), 32'((c % 3) == 0));
            check_vec($sformatf("b2b_rvalid%0d", c), 32'(resp_valid), 32'((c % 3) == 2));
            if ((c % 3) == 2) check_vec($sformatf("b2b_rdata%0d", c), resp_rdata, 32'h1234AA55);
            if (req_ready && req_valid) acc++;
            @(posedge clk); #1;
            if (acc == 3) req_valid = 1'b0;
        end
        check_vec("b2b_accepts", 32'(acc), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
